// File: rtl/convertisseur_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package convertisseur_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } etat_t;

  localparam logic [3:0] SEUIL_CHIFFRE      = 4'd4;
  localparam logic [3:0] CORRECTION_CHIFFRE = 4'd3;

  function automatic int bcdWidth(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/convertisseur_bcd_seq_correcteur.sv
// One double-dabble digit adjust: add 3 (mod 16) when the digit exceeds 4.
module correcteur_chiffre
  import convertisseur_bcd_pkg::*;
(
  input  logic [3:0] chiffreIn,
  output logic [3:0] chiffreOut
);

  // add-3 correction ahead of the shift
  always_comb begin
    chiffreOut = chiffreIn;
    if (chiffreIn > SEUIL_CHIFFRE) begin
      chiffreOut = chiffreIn + CORRECTION_CHIFFRE;
    end else begin
      chiffreOut = chiffreIn;
    end
  end

endmodule

// File: rtl/convertisseur_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (double dabble), one operand bit per clock.
// Optional two's-complement input when CONV_BCD_SIGNED_EN is defined.
module convertisseur_bcd_seq
  import convertisseur_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BIN_WIDTH-1:0]   binaireIn,
  input  logic                   valideIn,
  output logic                   pretOut,
  output logic [4*DIGITS-1:0]    bcdOut,
  output logic                   valideOut,
  input  logic                   pretIn,
  output logic                   debordOut,
  output logic                   signeOut
);

  localparam int BCD_WIDTH = bcdWidth(DIGITS);
  localparam int CNT_WIDTH = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BIN_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  etat_t                  etat_r, etatNext_s;
  logic [BIN_WIDTH-1:0]   operand_r, operandCapture_s;
  logic [BCD_WIDTH-1:0]   bcdWork_r, bcdAdj_s, bcdShift_s;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   overflow_r, overflowNext_s;
  logic                   pretOut_r, valideOut_r, debordOut_r;
  logic [BCD_WIDTH-1:0]   bcdOut_r;
  logic                   pretNext_s, valideNext_s;
  logic                   handshakeIn_s, handshakeOut_s, lastShift_s;

  assign handshakeIn_s  = valideIn && pretOut_r;
  assign handshakeOut_s = valideOut_r && pretIn;
  assign lastShift_s    = (etat_r == SHIFT) && (cnt_r == CNT_LAST);

  for (genvar g = 0; g < DIGITS; g++) begin : gen_correcteur
    correcteur_chiffre u_correcteur (
      .chiffreIn  (bcdWork_r[4*g +: 4]),
      .chiffreOut (bcdAdj_s[4*g +: 4])
    );
  end

  // The adjusted MSB is about to be shifted out, so it marks an overflow.
  assign bcdShift_s     = {bcdAdj_s[BCD_WIDTH-2:0], operand_r[BIN_WIDTH-1]};
  assign overflowNext_s = overflow_r | bcdAdj_s[BCD_WIDTH-1];

`ifdef CONV_BCD_SIGNED_EN
  logic signCapture_s, signWork_r, signeOut_r;

  // magnitude and sign of a two's-complement operand at capture
  always_comb begin
    operandCapture_s = binaireIn;
    signCapture_s    = 1'b0;
    if (binaireIn[BIN_WIDTH-1]) begin
      operandCapture_s = -binaireIn;
      signCapture_s    = 1'b1;
    end else begin
      operandCapture_s = binaireIn;
      signCapture_s    = 1'b0;
    end
  end

  // sign is tracked alongside the conversion and published with the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      signWork_r <= 1'b0;
      signeOut_r <= 1'b0;
    end else begin
      if (etat_r == IDLE && handshakeIn_s) begin
        signWork_r <= signCapture_s;
      end
      if (lastShift_s) begin
        signeOut_r <= signWork_r;
      end
    end
  end

  assign signeOut = signeOut_r;
`else
  assign operandCapture_s = binaireIn;
  assign signeOut         = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      etat_r <= IDLE;
    end else begin
      etat_r <= etatNext_s;
    end
  end

  // next-state logic
  always_comb begin
    etatNext_s = etat_r;
    case (etat_r)
      IDLE:    etatNext_s = handshakeIn_s  ? SHIFT : IDLE;
      SHIFT:   etatNext_s = lastShift_s    ? DONE  : SHIFT;
      DONE:    etatNext_s = handshakeOut_s ? IDLE  : DONE;
      default: etatNext_s = IDLE;
    endcase
  end

  // handshake outputs decoded from the next state so they can be registered
  always_comb begin
    pretNext_s   = 1'b0;
    valideNext_s = 1'b0;
    case (etatNext_s)
      IDLE:    pretNext_s   = 1'b1;
      DONE:    valideNext_s = 1'b1;
      default: begin
        pretNext_s   = 1'b0;
        valideNext_s = 1'b0;
      end
    endcase
  end

  // datapath: capture, shift-and-adjust, result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      operand_r   <= '0;
      bcdWork_r   <= '0;
      cnt_r       <= '0;
      overflow_r  <= 1'b0;
      pretOut_r   <= 1'b1;
      valideOut_r <= 1'b0;
      bcdOut_r    <= '0;
      debordOut_r <= 1'b0;
    end else begin
      pretOut_r   <= pretNext_s;
      valideOut_r <= valideNext_s;
      case (etat_r)
        IDLE: begin
          if (handshakeIn_s) begin
            operand_r  <= operandCapture_s;
            bcdWork_r  <= '0;
            cnt_r      <= '0;
            overflow_r <= 1'b0;
          end
        end
        SHIFT: begin
          operand_r  <= operand_r << 1;
          bcdWork_r  <= bcdShift_s;
          cnt_r      <= cnt_r + CNT_ONE;
          overflow_r <= overflowNext_s;
          if (lastShift_s) begin
            bcdOut_r    <= bcdShift_s;
            debordOut_r <= overflowNext_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pretOut   = pretOut_r;
  assign valideOut = valideOut_r;
  assign bcdOut    = bcdOut_r;
  assign debordOut = debordOut_r;

endmodule
